// File: rtl/perf_counter_bank.sv
// Shared bank of wrapping performance counters with sticky overflow flags and one registered read port.
// Optional `PERF_SNAPSHOT_EN` adds a snap input and shadow copies that reads are served from.
module perf_counter_bank #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 48,
    parameter int unsigned INC_W  = 3,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH*INC_W-1:0] evt_inc,
    input  logic [NUM_CH-1:0]       clr,
    input  logic                    rd_req,
    input  logic [IDX_W-1:0]        rd_idx,
`ifdef PERF_SNAPSHOT_EN
    input  logic                    snap,
`endif
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        rd_data,
    output logic                    rd_ovf,
    output logic [NUM_CH-1:0]       ovf
);

    localparam logic [IDX_W:0] NumChIdx = (IDX_W + 1)'(NUM_CH);

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [CNT_W:0]   sum   [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sum
        assign sum[i] = {1'b0, cnt_q[i]}
                      + {{(CNT_W + 1 - INC_W){1'b0}}, evt_inc[i*INC_W +: INC_W]};
    end

    // Clear wins over increment and ignores the global enable.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (en) begin
                cnt_d[i] = sum[i][CNT_W-1:0];
                ovf_d[i] = ovf_q[i] | sum[i][CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '{default: '0};
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    logic [CNT_W-1:0]  src_cnt [NUM_CH];
    logic [NUM_CH-1:0] src_ovf;

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0]  sh_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] sh_ovf_q;

    // Shadow captures pre-update register values, giving a coherent view across channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_cnt_q <= '{default: '0};
            sh_ovf_q <= '0;
        end else if (snap) begin
            sh_cnt_q <= cnt_q;
            sh_ovf_q <= ovf_q;
        end
    end

    always_comb begin
        src_cnt = sh_cnt_q;
        src_ovf = sh_ovf_q;
    end
`else
    always_comb begin
        src_cnt = cnt_q;
        src_ovf = ovf_q;
    end
`endif

    logic [CNT_W-1:0] sel_data;
    logic             sel_ovf;

    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        if ({1'b0, rd_idx} < NumChIdx) begin
            sel_data = src_cnt[rd_idx];
            sel_ovf  = src_ovf[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_data;
                rd_ovf  <= sel_ovf;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank (NUM_CH=6, CNT_W=8, INC_W=3).
// Build with PERF_SNAPSHOT_EN defined to exercise the shadow-read sequence instead.
module tb_perf_counter_bank;

    localparam int NCH = 6;
    localparam int CW  = 8;
    localparam int IW  = 3;
    localparam int XW  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [NCH*IW-1:0] evt_inc = '0;
    logic [NCH-1:0]   clr = '0;
    logic             rd_req = 1'b0;
    logic [XW-1:0]    rd_idx = '0;
    logic             snap = 1'b0;
    logic             rd_valid;
    logic [CW-1:0]    rd_data;
    logic             rd_ovf;
    logic [NCH-1:0]   ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    d;
        bit    o;
        string nm;
    } exp_t;

    exp_t exp_q[$];
    bit   req_pend = 1'b0;

    perf_counter_bank #(
        .NUM_CH(NCH),
        .CNT_W (CW),
        .INC_W (IW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .evt_inc (evt_inc),
        .clr     (clr),
        .rd_req  (rd_req),
        .rd_idx  (rd_idx),
`ifdef PERF_SNAPSHOT_EN
        .snap    (snap),
`endif
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_ovf  (rd_ovf),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(int ch, int v);
        evt_inc[ch*IW +: IW] = IW'(v);
    endtask

    task automatic run(int ch, int v, int n);
        set_inc(ch, v);
        repeat (n) tick();
        set_inc(ch, 0);
    endtask

    task automatic rd(int idx, int ed, bit eo, string nm);
        exp_t e;
        e.d = ed; e.o = eo; e.nm = nm;
        exp_q.push_back(e);
        rd_req = 1'b1;
        rd_idx = XW'(idx);
        tick();
        rd_req = 1'b0;
    endtask

    // Monitor: a request seen at an edge must yield exactly one response visible after that edge.
    always @(posedge clk) req_pend = rst ? rd_req : 1'b0;

    always @(negedge clk) begin
        if (rst && (rd_valid || req_pend)) begin
            chk("rd_valid_latency", int'(rd_valid), int'(req_pend));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.nm, "_data"}, int'(rd_data), e.d);
                    chk({e.nm, "_ovf"}, int'(rd_ovf), int'(e.o));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (2) tick();
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_rd_ovf", int'(rd_ovf), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b1;
        tick();
        en = 1'b1;

`ifdef PERF_SNAPSHOT_EN
        run(0, 4, 5);                       // ch0 = 20
        snap = 1'b1;
        set_inc(0, 1);
        tick();                             // shadow 20, ch0 21
        snap = 1'b0;
        repeat (3) tick();                  // ch0 24
        set_inc(0, 0);
        rd(0, 20, 1'b0, "snap_first");
        snap = 1'b1;
        tick();
        snap = 1'b0;
        rd(0, 24, 1'b0, "snap_second");
        run(0, 2, 1);                       // ch0 26
        snap = 1'b1;
        rd(0, 24, 1'b0, "snap_same_cycle");
        snap = 1'b0;
        rd(0, 26, 1'b0, "snap_after");
        rd(7, 0, 1'b0, "snap_out_of_range");
        chk("snap_live_ovf", int'(ovf), 0);
`else
        run(0, 3, 10);
        rd(0, 30, 1'b0, "ch0_accum");

        run(1, 2, 127);                     // ch1 = 254
        run(1, 5, 1);                       // 259 wraps to 3
        chk("ch1_ovf_set", int'(ovf), 'b000010);
        rd(1, 3, 1'b1, "ch1_wrap");
        run(1, 1, 3);
        chk("ch1_ovf_sticky", int'(ovf), 'b000010);
        rd(1, 6, 1'b1, "ch1_after_wrap");

        run(2, 7, 50);                      // 350 mod 256 = 94, overflowed
        run(2, 6, 1);                       // 100
        chk("ch2_ovf_set", int'(ovf), 'b000110);
        begin
            exp_t e;
            e.d = 100; e.o = 1'b1; e.nm = "clr_same_cycle_read";
            exp_q.push_back(e);
            clr = 'b000100;
            set_inc(2, 7);
            rd_req = 1'b1;
            rd_idx = 3'd2;
            tick();
            clr = '0;
            set_inc(2, 0);
            rd_req = 1'b0;
        end
        chk("ch2_ovf_cleared", int'(ovf), 'b000010);
        rd(2, 0, 1'b0, "ch2_cleared");

        rd(0, 30, 1'b0, "b2b_0");
        rd(1, 6, 1'b1, "b2b_1");
        rd(2, 0, 1'b0, "b2b_2");
        rd(1, 6, 1'b1, "b2b_1_again");
        rd(6, 0, 1'b0, "oor_6");
        rd(0, 30, 1'b0, "b2b_0_again");
        rd(7, 0, 1'b0, "oor_7");

        set_inc(3, 5);
        set_inc(4, 1);
        set_inc(5, 7);
        repeat (4) tick();
        evt_inc = '0;
        rd(3, 20, 1'b0, "multi_ch3");
        rd(4, 4, 1'b0, "multi_ch4");
        rd(5, 28, 1'b0, "multi_ch5");

        en = 1'b0;
        evt_inc = '1;
        repeat (5) tick();
        evt_inc = '0;
        rd(0, 30, 1'b0, "hold_ch0");
        rd(1, 6, 1'b1, "hold_ch1");
        rd(3, 20, 1'b0, "hold_ch3");
        rd(5, 28, 1'b0, "hold_ch5");
        chk("hold_ovf", int'(ovf), 'b000010);
        clr = 'b000001;
        tick();
        clr = '0;
        rd(0, 0, 1'b0, "clr_while_disabled");
        en = 1'b1;

        // Reset lands while a response is on the outputs; that response is cancelled.
        evt_inc = '1;
        rd(3, 20, 1'b0, "cancelled");
        chk("pre_reset_rd_valid", int'(rd_valid), 1);
        chk("pre_reset_rd_data", int'(rd_data), 20);
        #2 rst = 1'b0;
        #1;
        chk("mid_reset_rd_valid", int'(rd_valid), 0);
        chk("mid_reset_rd_data", int'(rd_data), 0);
        chk("mid_reset_rd_ovf", int'(rd_ovf), 0);
        chk("mid_reset_ovf", int'(ovf), 0);
        void'(exp_q.pop_front());
        evt_inc = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rd(1, 0, 1'b0, "post_reset_ch1");
        rd(5, 0, 1'b0, "post_reset_ch5");
`endif

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
